// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generation, load-use / HI-LO hazard detection and
// mult/div occupancy sequencing for the 5-stage MIPS pipeline.
module fwd_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_muldiv,
  input  logic       id_is_div,
  input  logic       id_reads_hilo,
  input  logic       id_ex_regwrite,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_memread,
  input  logic       id_ex_is_link,
  input  logic       ex_mem_regwrite,
  input  logic [4:0] ex_mem_rd,
  output logic [1:0] rs_fsel,
  output logic [1:0] rt_fsel,
  output logic       pc_hold,
  output logic       if_id_hold,
  output logic       id_ex_bubble,
  output logic       muldiv_busy,
  output logic       muldiv_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] SEL_RF   = 2'd0;
  localparam logic [1:0] SEL_EXM  = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;
  localparam logic [1:0] SEL_WB   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       r_rs_fsel;
  logic [1:0]       r_rt_fsel;

  logic             w_rs_load_hit;
  logic             w_rt_load_hit;
  logic             w_load_use;
  logic             w_md_hazard;
  logic             w_stall;
  logic [9:0]       w_src;
  logic [3:0]       w_fsel_next;

  // Hazard detection: register 0 is never a real dependency.
  assign w_rs_load_hit = id_uses_rs && (id_ex_rd == id_rs);
  assign w_rt_load_hit = id_uses_rt && (id_ex_rd == id_rt);
  assign w_load_use    = id_ex_memread && (id_ex_rd != 5'd0) && (w_rs_load_hit || w_rt_load_hit);
  assign w_md_hazard   = (r_state != ST_IDLE) && (id_is_muldiv || id_reads_hilo);
  assign w_stall       = w_load_use || w_md_hazard;

  assign pc_hold      = w_stall;
  assign if_id_hold   = w_stall;
  assign id_ex_bubble = w_stall;

  // Operand 0 is rs, operand 1 is rt; the EX producer is nearer and wins over MEM.
  assign w_src = {id_rt, id_rs};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic w_ex_hit;
      logic w_mem_hit;

      assign w_ex_hit  = id_ex_regwrite && (id_ex_rd != 5'd0) && (id_ex_rd == w_src[gi*5 +: 5]);
      assign w_mem_hit = ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == w_src[gi*5 +: 5]);

      assign w_fsel_next[gi*2 +: 2] = w_stall   ? SEL_RF :
                                      w_ex_hit  ? (id_ex_is_link ? SEL_LINK : SEL_EXM) :
                                      w_mem_hit ? SEL_WB : SEL_RF;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_fsel <= SEL_RF;
      r_rt_fsel <= SEL_RF;
    end else begin
      r_rs_fsel <= w_fsel_next[1:0];
      r_rt_fsel <= w_fsel_next[3:2];
    end
  end

  assign rs_fsel = r_rs_fsel;
  assign rt_fsel = r_rt_fsel;

  // Down-counter is loaded with N-1 so BUSY spans exactly N cycles before DONE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (id_is_muldiv && !w_stall) begin
          w_state_next = ST_BUSY;
          w_cnt_next   = id_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign muldiv_busy = (r_state != ST_IDLE);
  assign muldiv_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed pipeline-program bench for fwd_hazard_ctrl: a small pipeline shifter
// feeds ID/EX/MEM fields while a rule-level model checks every cycle.
module tb_fwd_hazard_ctrl;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, id_ex_rd, ex_mem_rd;
  logic       id_uses_rs, id_uses_rt, id_is_muldiv, id_is_div, id_reads_hilo;
  logic       id_ex_regwrite, id_ex_memread, id_ex_is_link, ex_mem_regwrite;
  logic [1:0] rs_fsel, rt_fsel;
  logic       pc_hold, if_id_hold, id_ex_bubble, muldiv_busy, muldiv_done;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .id_is_div(id_is_div), .id_reads_hilo(id_reads_hilo),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
    .id_ex_is_link(id_ex_is_link), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .rs_fsel(rs_fsel), .rt_fsel(rt_fsel), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .id_ex_bubble(id_ex_bubble), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
  );

  typedef struct packed {
    logic [3:0] tag;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       wr;
    logic [4:0] rd;
    logic       ld;
    logic       lnk;
    logic       md;
    logic       dv;
    logic       hl;
  } ins_t;

  localparam ins_t NOP = '0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- rule-level reference model ----------------
  int         md_rem = 0;   // cycles the mult/div unit stays occupied, incl. current
  logic [1:0] e_rs = 2'd0;
  logic [1:0] e_rt = 2'd0;
  logic       e_stall = 1'b0;

  function automatic logic [1:0] fwd_of(input logic [4:0] a);
    if (id_ex_regwrite && id_ex_rd != 0 && id_ex_rd == a) return id_ex_is_link ? 2'd2 : 2'd1;
    if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == a) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic stall_of();
    logic lu, mh;
    lu = id_ex_memread && id_ex_rd != 0 &&
         ((id_uses_rs && id_ex_rd == id_rs) || (id_uses_rt && id_ex_rd == id_rt));
    mh = (md_rem > 0) && (id_is_muldiv || id_reads_hilo);
    return lu || mh;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        md_rem = 0;
        e_rs   = 2'd0;
        e_rt   = 2'd0;
      end
      e_stall = stall_of();
      chk("rs_fsel", rs_fsel, e_rs);
      chk("rt_fsel", rt_fsel, e_rt);
      chk("pc_hold", pc_hold, e_stall);
      chk("if_id_hold", if_id_hold, e_stall);
      chk("id_ex_bubble", id_ex_bubble, e_stall);
      chk("muldiv_busy", muldiv_busy, md_rem > 0);
      chk("muldiv_done", muldiv_done, md_rem == 1);
      @(posedge clk);
      if (rst_n) begin
        e_rs = e_stall ? 2'd0 : fwd_of(id_rs);
        e_rt = e_stall ? 2'd0 : fwd_of(id_rt);
        if (md_rem > 0) md_rem--;
        else if (id_is_muldiv && !e_stall) md_rem = (id_is_div ? DIV_N : MULT_N) + 1;
      end
    end
  end

  // ---------------- pipeline stimulus ----------------
  ins_t prog[$];
  ins_t p_id = NOP, p_ex = NOP, p_mem = NOP;
  logic rst_drv = 1'b0;
  int   stall_cnt, busy_cnt, done_cnt;
  int   obs_rs[16];
  int   obs_rt[16];

  function automatic ins_t alu(input int tag, input int rd, input int rs, input int rt);
    ins_t i = NOP;
    i.tag = 4'(tag); i.rd = 5'(rd); i.rs = 5'(rs); i.rt = 5'(rt);
    i.urs = 1'b1; i.urt = 1'b1; i.wr = 1'b1;
    return i;
  endfunction

  function automatic ins_t lw(input int tag, input int rt, input int base);
    ins_t i = NOP;
    i.tag = 4'(tag); i.rs = 5'(base); i.urs = 1'b1; i.rt = 5'(rt);
    i.rd = 5'(rt); i.wr = 1'b1; i.ld = 1'b1;
    return i;
  endfunction

  function automatic ins_t jal(input int tag);
    ins_t i = NOP;
    i.tag = 4'(tag); i.rd = 5'd31; i.wr = 1'b1; i.lnk = 1'b1;
    return i;
  endfunction

  function automatic ins_t jr(input int tag, input int rs);
    ins_t i = NOP;
    i.tag = 4'(tag); i.rs = 5'(rs); i.urs = 1'b1;
    return i;
  endfunction

  function automatic ins_t muldiv(input int tag, input bit is_div);
    ins_t i = NOP;
    i.tag = 4'(tag); i.rs = 5'd1; i.rt = 5'd2; i.urs = 1'b1; i.urt = 1'b1;
    i.md = 1'b1; i.dv = is_div;
    return i;
  endfunction

  function automatic ins_t mfhi(input int tag, input int rd);
    ins_t i = NOP;
    i.tag = 4'(tag); i.rd = 5'(rd); i.wr = 1'b1; i.hl = 1'b1;
    return i;
  endfunction

  task automatic tick();
    @(negedge clk);
    rst_n           = rst_drv;
    id_rs           = p_id.rs;
    id_rt           = p_id.rt;
    id_uses_rs      = p_id.urs;
    id_uses_rt      = p_id.urt;
    id_is_muldiv    = p_id.md;
    id_is_div       = p_id.dv;
    id_reads_hilo   = p_id.hl;
    id_ex_regwrite  = p_ex.wr;
    id_ex_rd        = p_ex.rd;
    id_ex_memread   = p_ex.ld;
    id_ex_is_link   = p_ex.lnk;
    ex_mem_regwrite = p_mem.wr;
    ex_mem_rd       = p_mem.rd;
    #3;
    if (p_ex.tag != 0) begin
      obs_rs[p_ex.tag] = rs_fsel;
      obs_rt[p_ex.tag] = rt_fsel;
    end
    stall_cnt += int'(pc_hold);
    busy_cnt  += int'(muldiv_busy);
    done_cnt  += int'(muldiv_done);
    @(posedge clk);
    if (!rst_n) begin
      p_id = NOP; p_ex = NOP; p_mem = NOP;
    end else if (e_stall) begin
      p_mem = p_ex; p_ex = NOP;
    end else begin
      p_mem = p_ex; p_ex = p_id;
      p_id  = (prog.size() > 0) ? prog.pop_front() : NOP;
    end
  endtask

  task automatic clear_obs();
    stall_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      obs_rs[k] = -1;
      obs_rt[k] = -1;
    end
  endtask

  task automatic run(input string name);
    int n = 0;
    clear_obs();
    while (n < 200 && !(prog.size() == 0 && p_id == NOP && p_ex == NOP && p_mem == NOP && md_rem == 0)) begin
      tick();
      n++;
    end
    if (n >= 200) chk({name, "_drain_timeout"}, 1, 0);
    tick();
    tick();
    $display("prog %-12s cycles=%0d stalls=%0d busy=%0d done=%0d", name, n, stall_cnt, busy_cnt, done_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    {id_rs, id_rt, id_ex_rd, ex_mem_rd} = '0;
    {id_uses_rs, id_uses_rt, id_is_muldiv, id_is_div, id_reads_hilo} = '0;
    {id_ex_regwrite, id_ex_memread, id_ex_is_link, ex_mem_regwrite} = '0;
    clear_obs();
    tick();
    tick();
    #1;
    chk("reset_rs_fsel", rs_fsel, 0);
    chk("reset_rt_fsel", rt_fsel, 0);
    chk("reset_busy", muldiv_busy, 0);
    chk("reset_done", muldiv_done, 0);
    chk("reset_pc_hold", pc_hold, 0);
    rst_drv = 1'b1;

    // add r3,r1,r2 ; sub r4,r3,r5
    prog.push_back(alu(1, 3, 1, 2));
    prog.push_back(alu(2, 4, 3, 5));
    run("back2back");
    chk("b2b_rs", obs_rs[2], 1);
    chk("b2b_rt", obs_rt[2], 0);
    chk("b2b_stalls", stall_cnt, 0);

    // add r3 ; nop ; or r6,r3,r3
    prog.push_back(alu(1, 3, 1, 2));
    prog.push_back(NOP);
    prog.push_back(alu(2, 6, 3, 3));
    run("dist2");
    chk("dist2_rs", obs_rs[2], 3);
    chk("dist2_rt", obs_rt[2], 3);

    // add r3 ; add r3 ; or r6,r3,r3 -> nearest producer
    prog.push_back(alu(1, 3, 1, 2));
    prog.push_back(alu(2, 3, 4, 5));
    prog.push_back(alu(3, 6, 3, 3));
    run("nearest");
    chk("nearest_rs", obs_rs[3], 1);
    chk("nearest_rt", obs_rt[3], 1);

    // producers targeting r0 never forward
    prog.push_back(alu(1, 0, 1, 2));
    prog.push_back(alu(2, 0, 1, 2));
    prog.push_back(alu(3, 6, 0, 0));
    run("r0");
    chk("r0_rs", obs_rs[3], 0);
    chk("r0_rt", obs_rt[3], 0);

    // jal ; jr r31
    prog.push_back(jal(1));
    prog.push_back(jr(2, 31));
    run("link");
    chk("link_rs", obs_rs[2], 2);

    // lw r5 ; add r6,r5,r0
    prog.push_back(lw(1, 5, 1));
    prog.push_back(alu(2, 6, 5, 0));
    run("load_use");
    chk("lu_stalls", stall_cnt, 1);
    chk("lu_rs", obs_rs[2], 3);
    chk("lu_rt", obs_rt[2], 0);

    // mult ; mfhi
    prog.push_back(muldiv(1, 1'b0));
    prog.push_back(mfhi(2, 8));
    run("mult_mfhi");
    chk("mult_stalls", stall_cnt, 5);
    chk("mult_busy", busy_cnt, 5);
    chk("mult_done", done_cnt, 1);

    // div ; mfhi
    prog.push_back(muldiv(1, 1'b1));
    prog.push_back(mfhi(2, 8));
    run("div_mfhi");
    chk("div_stalls", stall_cnt, 33);
    chk("div_busy", busy_cnt, 33);
    chk("div_done", done_cnt, 1);

    // div ; add (independent) ; mfhi
    prog.push_back(muldiv(1, 1'b1));
    prog.push_back(alu(2, 9, 1, 2));
    prog.push_back(mfhi(3, 8));
    run("div_add");
    chk("divadd_stalls", stall_cnt, 32);
    chk("divadd_busy", busy_cnt, 33);
    chk("divadd_add_rs", obs_rs[2], 0);

    // reset while a div is busy
    clear_obs();
    prog.push_back(muldiv(1, 1'b1));
    for (int k = 0; k < 4; k++) tick();
    #1;
    chk("pre_rst_busy", muldiv_busy, 1);
    rst_drv = 1'b0;
    tick();
    #1;
    chk("rst_mid_busy", muldiv_busy, 0);
    chk("rst_mid_done", muldiv_done, 0);
    chk("rst_mid_rs", rs_fsel, 0);
    rst_drv = 1'b1;
    prog.push_back(mfhi(2, 8));
    run("rst_mfhi");
    chk("rst_mfhi_stalls", stall_cnt, 0);
    chk("rst_mfhi_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Pipeline control block for the 5-stage MIPS core. It computes the 2-bit forwarding selects that drive the rs/rt forwarding muxes at the EX stage, and detects load-use hazards. It also sequences the multi-cycle mult/div unit (busy/done FSM) and issues stall/bubble controls to PC, IF/ID and ID/EX. Forwarding selects are registered on the same edge as the ID/EX register, so they are valid for the whole EX cycle.

Parameters:
MULT_CYCLES, 4, EX-side latency of mult/multu in cycles (>=1)
DIV_CYCLES, 32, latency of div/divu in cycles (>=1)
CNT_W, 6, width of the mult/div down-counter; must hold DIV_CYCLES-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_muldiv  in  1  ID instruction is mult/multu/div/divu
id_is_div  in  1  qualifies id_is_muldiv: div/divu
id_reads_hilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
id_ex_regwrite  in  1  instruction in EX writes a GPR
id_ex_rd  in  5  destination of instruction in EX
id_ex_memread  in  1  instruction in EX is a load
id_ex_is_link  in  1  instruction in EX is jal/jalr; its result is PC+4
ex_mem_regwrite  in  1  instruction in MEM writes a GPR
ex_mem_rd  in  5  destination of instruction in MEM
rs_fsel  out  2  rs forwarding select: 0 regfile, 1 EX/MEM result, 2 EX/MEM PC+4, 3 WB mux
rt_fsel  out  2  rt forwarding select, same encoding
pc_hold  out  1  hold PC
if_id_hold  out  1  hold IF/ID register
id_ex_bubble  out  1  load NOP into ID/EX
muldiv_busy  out  1  mult/div unit occupied (state != IDLE)
muldiv_done  out  1  one-cycle pulse: HI/LO written at end of this cycle

Behaviour:
- Reset (async, rst_n=0): rs_fsel=rt_fsel=0, FSM=IDLE, counter=0, muldiv_busy=0, muldiv_done=0. Stall outputs are combinational and read 0 once FSM=IDLE and no load-use condition holds.
- match(a,r,we) = we && r!=0 && r==a. Register 0 never forwards and never stalls.
- load_use = id_ex_memread && id_ex_rd!=0 && ((id_uses_rs && id_ex_rd==id_rs) || (id_uses_rt && id_ex_rd==id_rt)).
- md_hazard = (state!=IDLE) && (id_is_muldiv || id_reads_hilo).
- stall = load_use | md_hazard. pc_hold = if_id_hold = id_ex_bubble = stall, all combinational, same cycle. Simultaneous causes produce a single stall with no double count.
- Forwarding selects, updated every rising edge:
  - If stall: rs_fsel and rt_fsel <= 0, because the bubble enters EX.
  - Else, for each of rs/rt independently:
    - match(id_rs, id_ex_rd, id_ex_regwrite): select <= id_ex_is_link ? 2 : 1.
    - Else match(id_rs, ex_mem_rd, ex_mem_regwrite): select <= 3.
    - Else select <= 0.
  - Nearer producer wins. id_uses_* does not gate the selects (a harmless select). A load in EX never yields 1, because load_use stalls first. On release the load is in MEM, giving select 3.
- Mult/div FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when id_is_muldiv && !stall. Counter <= (id_is_div ? DIV_CYCLES : MULT_CYCLES) - 1.
  - BUSY: counter decrements each cycle. When counter==0, go to DONE. BUSY therefore lasts exactly N cycles.
  - DONE: muldiv_done=1 for one cycle, then IDLE.
  - muldiv_busy=1 in BUSY and DONE. A HI/LO reader or a new mult/div in ID stalls N+1 cycles when it immediately follows its producer.
  - Independent ALU instructions proceed while BUSY.
- Accept and release are edge-aligned: a stalled mult/div is accepted on the first edge where the FSM is IDLE.
- Reset mid-BUSY aborts the operation: FSM=IDLE, no muldiv_done pulse.

Test Plan:
1. Back-to-back hazard: add r3,r1,r2 then sub r4,r3,r5 -> no stall; in the sub's EX cycle rs_fsel=1, rt_fsel=0.
2. Distance-2 and priority: add r3 then nop then or r6,r3,r3 -> rs_fsel=rt_fsel=3. With add r3; add r3; or r6,r3 -> 1 (nearest wins). Any producer with rd=0 -> 0.
3. Link forwarding: jal writing r31 immediately followed by jr r31 -> rs_fsel=2.
4. Load-use: lw r5 then add r6,r5,r0 -> exactly one cycle with pc_hold=if_id_hold=id_ex_bubble=1 and selects 0; next EX cycle rs_fsel=3.
5. Mult/div sequencing: mult followed by mfhi (MULT_CYCLES=4) -> muldiv_busy high 5 cycles, muldiv_done pulses on the 5th, mfhi stalled 5 cycles. Repeat with div and DIV_CYCLES=32 -> 33. An independent add between them is not stalled.
6. Reset mid-operation: assert rst_n=0 during BUSY of a div -> outputs immediately 0 and FSM IDLE, no muldiv_done; after release, a mfhi in ID does not stall.
